// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter: MEM loads/stores pre-empt instruction fetch, stores run a setup/pulse/recovery FSM.
// Define RAM_ARB_WAIT_EN to stretch the write-enable pulse to two cycles (adds WR_WAIT).
module ram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_addr,
  output logic [15:0] if_inst,
  input  logic [1:0]  mem_op,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        ram_pause,
  output logic        ovf_err,
  output logic [17:0] ram_addr,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam logic [1:0]  OP_RD    = 2'b01;
  localparam logic [1:0]  OP_WR    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_PULSE = 2'd1,
    S_WR_WAIT  = 2'd2,
    S_WR_REC   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        pv_q, pv_d;
  logic        pop_q, pop_d;
  logic [15:0] paddr_q, paddr_d;
  logic [15:0] pdata_q, pdata_d;
  logic        ovf_q, ovf_d;

  logic        req_valid;
  logic        req_wr;
  logic        srv_valid;
  logic        srv_wr;
  logic [15:0] srv_addr;
  logic [15:0] srv_data;
  logic        slot_load;
  logic [15:0] bus_addr;

  // Opcode 11 is deliberately ignored, exactly like 00.
  assign req_valid = (mem_op == OP_RD) || (mem_op == OP_WR);
  assign req_wr    = (mem_op == OP_WR);

  // A pending request always wins over a new one; the new one refills the slot.
  assign srv_valid = pv_q | req_valid;
  assign srv_wr    = pv_q ? pop_q   : req_wr;
  assign srv_addr  = pv_q ? paddr_q : mem_addr;
  assign srv_data  = pv_q ? pdata_q : mem_wdata;

  assign ram_addr = {2'b00, bus_addr};
  assign ovf_err  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 16'h0000;
      pv_q      <= 1'b0;
      pop_q     <= 1'b0;
      paddr_q   <= 16'h0000;
      pdata_q   <= 16'h0000;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      pv_q      <= pv_d;
      pop_q     <= pop_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pv_d       = pv_q;
    pop_d      = pop_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    ovf_d      = ovf_q;
    slot_load  = 1'b0;

    bus_addr   = if_addr;
    ram_dq_o   = wr_data_q;
    ram_dq_oe  = 1'b0;
    ram_ce_n   = 1'b0;
    ram_oe_n   = 1'b1;
    ram_we_n   = 1'b1;
    if_inst    = NOP_INST;
    mem_rdata  = ram_dq_i;
    mem_rvalid = 1'b0;
    ram_pause  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (srv_valid) begin
          ram_pause = 1'b1;
          bus_addr  = srv_addr;
          if (srv_wr) begin
            wr_addr_d = srv_addr;
            wr_data_d = srv_data;
            ram_dq_o  = srv_data;
            ram_dq_oe = 1'b1;
            state_d   = S_WR_PULSE;
          end else begin
            ram_oe_n   = 1'b0;
            mem_rvalid = 1'b1;
          end
          if (pv_q) begin
            pv_d      = req_valid;
            slot_load = req_valid;
          end
        end else begin
          ram_oe_n = 1'b0;
          if_inst  = ram_dq_i;
        end
      end

      S_WR_PULSE: begin
        bus_addr  = wr_addr_q;
        ram_dq_oe = 1'b1;
        ram_we_n  = 1'b0;
        ram_pause = 1'b1;
`ifdef RAM_ARB_WAIT_EN
        state_d   = S_WR_WAIT;
`else
        state_d   = S_WR_REC;
`endif
      end

`ifdef RAM_ARB_WAIT_EN
      S_WR_WAIT: begin
        bus_addr  = wr_addr_q;
        ram_dq_oe = 1'b1;
        ram_we_n  = 1'b0;
        ram_pause = 1'b1;
        state_d   = S_WR_REC;
      end
`endif

      S_WR_REC: begin
        // Data stays driven one cycle past the rising we_n edge for hold time.
        bus_addr  = wr_addr_q;
        ram_dq_oe = 1'b1;
        ram_pause = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests landing while a write owns the bus go to the slot, or are lost if it is full.
    if (state_q != S_IDLE && req_valid) begin
      if (pv_q) begin
        ovf_d = 1'b1;
      end else begin
        pv_d      = 1'b1;
        slot_load = 1'b1;
      end
    end

    if (slot_load) begin
      pop_d   = req_wr;
      paddr_d = mem_addr;
      pdata_d = mem_wdata;
    end

    if (rst) begin
      ram_ce_n   = 1'b1;
      ram_oe_n   = 1'b1;
      ram_we_n   = 1'b1;
      ram_dq_oe  = 1'b0;
      ram_pause  = 1'b0;
      mem_rvalid = 1'b0;
      if_inst    = NOP_INST;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized run against
// a cycle-budget / pending-queue reference model and an asynchronous SRAM model.
module tb_ram_arbiter;

  localparam logic [15:0] NOP = 16'h0800;
`ifdef RAM_ARB_WAIT_EN
  localparam int WR_LEN = 4;
`else
  localparam int WR_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] if_addr;
  logic [15:0] if_inst;
  logic [1:0]  mem_op;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        ram_pause;
  logic        ovf_err;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_i;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter dut (
    .clk(clk), .rst(rst), .if_addr(if_addr), .if_inst(if_inst),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .ram_pause(ram_pause),
    .ovf_err(ovf_err), .ram_addr(ram_addr), .ram_dq_i(ram_dq_i),
    .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe), .ram_ce_n(ram_ce_n),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  // Contents of never-written SRAM words.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'h6A05;
    if (a == 16'h8000) return 16'h1234;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Asynchronous SRAM: combinational read, write captured while we_n is low.
  logic [15:0] sram_data [0:65535];
  bit          sram_wr   [0:65535];

  always_comb begin
    ram_dq_i = sram_wr[ram_addr[15:0]] ? sram_data[ram_addr[15:0]] : init_val(ram_addr[15:0]);
  end

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n && ram_dq_oe) begin
      sram_data[ram_addr[15:0]] <= ram_dq_o;
      sram_wr[ram_addr[15:0]]   <= 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    $display("reset: rst=1 with a write request present");
    rst = 1'b1; mem_op = 2'b10; mem_addr = 16'h8000; mem_wdata = 16'hFFFF; if_addr = 16'h0010;
    #2;
    n_cmp++; if (ram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", ram_we_n); end
    n_cmp++; if (ram_oe_n !== 1'b1) begin n_bad++; $display("FAIL reset_oe_n: got %b want 1", ram_oe_n); end
    n_cmp++; if (ram_ce_n !== 1'b1) begin n_bad++; $display("FAIL reset_ce_n: got %b want 1", ram_ce_n); end
    n_cmp++; if (ram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dq_oe: got %b want 0", ram_dq_oe); end
    n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL reset_pause: got %b want 0", ram_pause); end
    n_cmp++; if (mem_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", mem_rvalid); end
    n_cmp++; if (if_inst !== NOP) begin n_bad++; $display("FAIL reset_if_inst: got %h want %h", if_inst, NOP); end
    @(negedge clk);
    #2;
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf_err); end
    @(negedge clk);
    rst = 1'b0; mem_op = 2'b00;
    #2;
    n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL reset_after_pause: got %b want 0", ram_pause); end
    n_cmp++; if (ram_ce_n !== 1'b0) begin n_bad++; $display("FAIL reset_after_ce_n: got %b want 0", ram_ce_n); end
    @(negedge clk);
  endtask

  task automatic test_fetch();
    $display("fetch: if_addr=0010 for 4 cycles");
    mem_op = 2'b00; if_addr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_cmp++; if (if_inst !== 16'h6A05) begin n_bad++; $display("FAIL fetch_inst c%0d: got %h want 6a05", c, if_inst); end
      n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL fetch_pause c%0d: got %b want 0", c, ram_pause); end
      n_cmp++; if (ram_addr !== 18'h00010) begin n_bad++; $display("FAIL fetch_addr c%0d: got %h want 00010", c, ram_addr); end
      n_cmp++; if (ram_oe_n !== 1'b0 || ram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL fetch_strobes c%0d: got oe_n=%b dq_oe=%b want 0/0", c, ram_oe_n, ram_dq_oe); end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    $display("load: addr=8000");
    mem_op = 2'b01; mem_addr = 16'h8000;
    #2;
    n_cmp++; if (mem_rdata !== 16'h1234) begin n_bad++; $display("FAIL load_rdata: got %h want 1234", mem_rdata); end
    n_cmp++; if (mem_rvalid !== 1'b1) begin n_bad++; $display("FAIL load_rvalid: got %b want 1", mem_rvalid); end
    n_cmp++; if (ram_pause !== 1'b1) begin n_bad++; $display("FAIL load_pause: got %b want 1", ram_pause); end
    n_cmp++; if (if_inst !== NOP) begin n_bad++; $display("FAIL load_if_inst: got %h want %h", if_inst, NOP); end
    n_cmp++; if (ram_addr !== 18'h08000) begin n_bad++; $display("FAIL load_addr: got %h want 08000", ram_addr); end
    @(negedge clk);
    mem_op = 2'b00;
    #2;
    n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL load_next_pause: got %b want 0", ram_pause); end
    n_cmp++; if (mem_rvalid !== 1'b0) begin n_bad++; $display("FAIL load_next_rvalid: got %b want 0", mem_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_store();
    int we_low;
    $display("store: addr=8001 data=beef");
    we_low = 0;
    mem_op = 2'b10; mem_addr = 16'h8001; mem_wdata = 16'hBEEF;
    for (int c = 0; c < WR_LEN; c++) begin
      #2;
      if (ram_we_n === 1'b0) we_low++;
      n_cmp++; if (ram_pause !== 1'b1) begin n_bad++; $display("FAIL store_pause c%0d: got %b want 1", c, ram_pause); end
      n_cmp++; if (ram_dq_oe !== 1'b1) begin n_bad++; $display("FAIL store_dq_oe c%0d: got %b want 1", c, ram_dq_oe); end
      n_cmp++; if (ram_we_n !== ((c >= 1 && c <= WR_LEN - 2) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL store_we_n c%0d: got %b", c, ram_we_n); end
      n_cmp++; if (ram_dq_o !== 16'hBEEF || ram_addr !== 18'h08001) begin n_bad++; $display("FAIL store_bus c%0d: got %h@%h want beef@08001", c, ram_dq_o, ram_addr); end
      @(negedge clk);
      mem_op = 2'b00;
    end
    #2;
    n_cmp++; if (we_low != WR_LEN - 2) begin n_bad++; $display("FAIL store_we_count: got %0d want %0d", we_low, WR_LEN - 2); end
    n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL store_end_pause: got %b want 0", ram_pause); end
    @(negedge clk);
    $display("load: addr=8001 after store");
    mem_op = 2'b01; mem_addr = 16'h8001;
    #2;
    n_cmp++; if (mem_rvalid !== 1'b1 || mem_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL store_readback: got v=%b %h want v=1 beef", mem_rvalid, mem_rdata); end
    @(negedge clk);
    mem_op = 2'b00;
  endtask

  task automatic test_load_during_store();
    $display("store: addr=8003 data=a5c3, then load 8003 in pulse cycle");
    mem_op = 2'b10; mem_addr = 16'h8003; mem_wdata = 16'hA5C3;
    @(negedge clk);
    mem_op = 2'b01; mem_addr = 16'h8003; mem_wdata = 16'h0000;
    for (int c = 1; c < WR_LEN; c++) begin
      #2;
      n_cmp++; if (mem_rvalid !== 1'b0 || ram_pause !== 1'b1) begin n_bad++; $display("FAIL pend_wait c%0d: got v=%b p=%b want 0/1", c, mem_rvalid, ram_pause); end
      @(negedge clk);
      mem_op = 2'b00;
    end
    #2;
    n_cmp++; if (mem_rvalid !== 1'b1) begin n_bad++; $display("FAIL pend_rvalid: got %b want 1", mem_rvalid); end
    n_cmp++; if (mem_rdata !== 16'hA5C3) begin n_bad++; $display("FAIL pend_rdata: got %h want a5c3", mem_rdata); end
    n_cmp++; if (ram_pause !== 1'b1 || if_inst !== NOP) begin n_bad++; $display("FAIL pend_pause: got p=%b i=%h want 1/0800", ram_pause, if_inst); end
    n_cmp++; if (ram_dq_oe !== 1'b0 || ram_oe_n !== 1'b0) begin n_bad++; $display("FAIL pend_bus: got dq_oe=%b oe_n=%b want 0/0", ram_dq_oe, ram_oe_n); end
    @(negedge clk);
    #2;
    n_cmp++; if (ram_pause !== 1'b0 || mem_rvalid !== 1'b0) begin n_bad++; $display("FAIL pend_after: got p=%b v=%b want 0/0", ram_pause, mem_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    $display("overflow: store 8004, load 8000 in pulse, store 8005 next cycle");
    #2;
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_initial: got %b want 0", ovf_err); end
    mem_op = 2'b10; mem_addr = 16'h8004; mem_wdata = 16'h1111;
    @(negedge clk);
    mem_op = 2'b01; mem_addr = 16'h8000;
    @(negedge clk);
    mem_op = 2'b10; mem_addr = 16'h8005; mem_wdata = 16'h2222;
    @(negedge clk);
    mem_op = 2'b00;
    #2;
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf_err); end
    for (int c = 3; c < WR_LEN; c++) @(negedge clk);
    #2;
    n_cmp++; if (mem_rvalid !== 1'b1 || mem_rdata !== 16'h1234) begin n_bad++; $display("FAIL ovf_pend_load: got v=%b %h want v=1 1234", mem_rvalid, mem_rdata); end
    @(negedge clk);
    #2;
    n_cmp++; if (ram_pause !== 1'b0) begin n_bad++; $display("FAIL ovf_dropped_pause: got %b want 0", ram_pause); end
    @(negedge clk);
    mem_op = 2'b01; mem_addr = 16'h8005;
    #2;
    n_cmp++; if (mem_rdata !== init_val(16'h8005)) begin n_bad++; $display("FAIL ovf_dropped_data: got %h want %h", mem_rdata, init_val(16'h8005)); end
    @(negedge clk);
    mem_addr = 16'h8004;
    #2;
    n_cmp++; if (mem_rdata !== 16'h1111) begin n_bad++; $display("FAIL ovf_first_store: got %h want 1111", mem_rdata); end
    @(negedge clk);
    mem_op = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    $display("reset mid-write: store 8006 data=7777, rst in pulse cycle");
    mem_op = 2'b10; mem_addr = 16'h8006; mem_wdata = 16'h7777; if_addr = 16'h0010;
    @(negedge clk);
    mem_op = 2'b00; rst = 1'b1;
    #2;
    n_cmp++; if (ram_we_n !== 1'b1) begin n_bad++; $display("FAIL rstmid_we_n: got %b want 1", ram_we_n); end
    n_cmp++; if (ram_dq_oe !== 1'b0 || ram_pause !== 1'b0) begin n_bad++; $display("FAIL rstmid_bus: got dq_oe=%b p=%b want 0/0", ram_dq_oe, ram_pause); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    n_cmp++; if (ram_pause !== 1'b0 || if_inst !== 16'h6A05) begin n_bad++; $display("FAIL rstmid_fetch: got p=%b i=%h want 0/6a05", ram_pause, if_inst); end
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf_clear: got %b want 0", ovf_err); end
    @(negedge clk);
    $display("reset mid-write: store 8007, pend load 8000, rst in next cycle");
    mem_op = 2'b10; mem_addr = 16'h8007; mem_wdata = 16'h4444;
    @(negedge clk);
    mem_op = 2'b01; mem_addr = 16'h8000;
    @(negedge clk);
    mem_op = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_cmp++; if (mem_rvalid !== 1'b0 || ram_pause !== 1'b0) begin n_bad++; $display("FAIL rstmid_discard c%0d: got v=%b p=%b want 0/0", c, mem_rvalid, ram_pause); end
      @(negedge clk);
    end
    mem_op = 2'b01; mem_addr = 16'h8006;
    #2;
    n_cmp++; if (mem_rdata !== init_val(16'h8006)) begin n_bad++; $display("FAIL rstmid_abandoned: got %h want %h", mem_rdata, init_val(16'h8006)); end
    @(negedge clk);
    mem_op = 2'b00;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  task automatic test_random();
    req_t        pend[$];
    req_t        req;
    req_t        srv;
    logic [15:0] shadow [0:15];
    int          wr_left;
    bit          m_ovf;
    bit          is_req;
    bit          have_srv;
    int          r;
    logic [1:0]  op;
    logic        exp_pause;
    logic        exp_rvalid;
    logic [15:0] exp_rdata;
    logic [15:0] exp_inst;

    rst = 1'b1; mem_op = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    wr_left = 0; m_ovf = 1'b0; pend.delete();
    for (int i = 0; i < 16; i++) shadow[i] = init_val(16'h9000 + 16'(i));

    for (int cyc = 0; cyc < 600; cyc++) begin
      r = int'($urandom_range(0, 99));
      op = (r < 55) ? 2'b00 : (r < 72) ? 2'b01 : (r < 90) ? 2'b10 : 2'b11;
      mem_op    = op;
      mem_addr  = 16'h9000 | 16'($urandom_range(0, 15));
      mem_wdata = 16'($urandom);
      if_addr   = 16'h0100 + 16'($urandom_range(0, 63));
      is_req = (op == 2'b01) || (op == 2'b10);
      if (is_req) $display("rand cyc=%0d op=%0d addr=%h data=%h", cyc, op, mem_addr, mem_wdata);
      #2;
      n_cmp++; if (ovf_err !== m_ovf) begin n_bad++; $display("FAIL rand_ovf cyc%0d: got %b want %b", cyc, ovf_err, m_ovf); end

      req.wr = (op == 2'b10); req.addr = mem_addr; req.data = mem_wdata;
      exp_pause = 1'b0; exp_rvalid = 1'b0; exp_rdata = 16'h0000; exp_inst = NOP;
      if (wr_left > 0) begin
        exp_pause = 1'b1;
        if (is_req) begin
          if (pend.size() == 0) pend.push_back(req);
          else m_ovf = 1'b1;
        end
        wr_left--;
      end else begin
        have_srv = 1'b0;
        if (pend.size() > 0) begin
          srv = pend.pop_front();
          have_srv = 1'b1;
          if (is_req) pend.push_back(req);
        end else if (is_req) begin
          srv = req;
          have_srv = 1'b1;
        end
        if (have_srv) begin
          exp_pause = 1'b1;
          if (srv.wr) begin
            shadow[srv.addr[3:0]] = srv.data;
            wr_left = WR_LEN - 1;
          end else begin
            exp_rvalid = 1'b1;
            exp_rdata  = shadow[srv.addr[3:0]];
          end
        end else begin
          exp_inst = init_val(if_addr);
        end
      end

      n_cmp++; if (ram_pause !== exp_pause) begin n_bad++; $display("FAIL rand_pause cyc%0d: got %b want %b", cyc, ram_pause, exp_pause); end
      n_cmp++; if (mem_rvalid !== exp_rvalid) begin n_bad++; $display("FAIL rand_rvalid cyc%0d: got %b want %b", cyc, mem_rvalid, exp_rvalid); end
      if (exp_rvalid) begin
        n_cmp++; if (mem_rdata !== exp_rdata) begin n_bad++; $display("FAIL rand_rdata cyc%0d: got %h want %h", cyc, mem_rdata, exp_rdata); end
      end
      n_cmp++; if (if_inst !== exp_inst) begin n_bad++; $display("FAIL rand_if_inst cyc%0d: got %h want %h", cyc, if_inst, exp_inst); end
      n_cmp++; if ((ram_dq_oe && !ram_oe_n) !== 1'b0 || ram_ce_n !== 1'b0 || ram_addr[17:16] !== 2'b00) begin
        n_bad++; $display("FAIL rand_bus cyc%0d: got dq_oe=%b oe_n=%b ce_n=%b hi=%b want no contention, ce_n=0, hi=00", cyc, ram_dq_oe, ram_oe_n, ram_ce_n, ram_addr[17:16]);
      end
      @(negedge clk);
    end
    mem_op = 2'b00;
  endtask

  initial begin
    rst = 1'b1; mem_op = 2'b00; if_addr = 16'h0010; mem_addr = 16'h0000; mem_wdata = 16'h0000;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_load_during_store();
    test_overflow();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
